// File: rtl/cam_pkg.sv
// Shared constants, state encoding and window helper for the camera-to-VRAM capture path.
package cam_pkg;

    localparam int IMG_W_DEF = 128;
    localparam int IMG_H_DEF = 128;
    localparam int H_OFS_DEF = 256;
    localparam int V_OFS_DEF = 176;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 12;
    localparam int CNT_W   = 11;
    localparam int WCNT_W  = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } cam_state_t;

    // True when a pixel/line index lies inside [lo, lo+len).
    function automatic logic in_span(input logic [CNT_W-1:0] v, input int lo, input int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/cam_vram_writer_if.sv
// VRAM port-A write bus driven by the camera capture block.
interface cam_vram_writer_if;
    import cam_pkg::*;

    logic               wea;
    logic [VRAM_AW-1:0] addra;
    logic [VRAM_DW-1:0] dina;

    modport master (output wea, output addra, output dina);
    modport slave  (input  wea, input  addra, input  dina);

endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for an asynchronous camera line, with a third stage for edge pulses.
module cam_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign level = sync2;
    assign rise  = sync2 & ~sync3;
    assign fall  = ~sync2 & sync3;

endmodule

// File: rtl/cam_vram_writer.sv
// Captures one cropped RGB444 frame from the parallel camera bus into the 16K x 12 VRAM.
module cam_vram_writer
    import cam_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int H_OFS = H_OFS_DEF,
    parameter int V_OFS = V_OFS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cam_pclk,
    input  logic                      cam_vsync,
    input  logic                      cam_href,
    input  logic [7:0]                cam_data,
    input  logic                      capture_req,
    cam_vram_writer_if.master         vram,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      short_frame
);

    localparam logic [WCNT_W-1:0] TOTAL = WCNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    cam_state_t state_q;
    cam_state_t state_d;

    logic pclk_lvl, pclk_rise, pclk_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic href_lvl, href_rise, href_fall;

    logic [7:0]          data_s1;
    logic [7:0]          data_s2;
    logic [CNT_W-1:0]    x_q;
    logic [CNT_W-1:0]    y_q;
    logic                phase_q;
    logic [3:0]          red_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                wea_q;
    logic [VRAM_AW-1:0]  addra_q;
    logic [VRAM_DW-1:0]  dina_q;
    logic                short_q;

    logic start_frame;
    logic in_window;
    logic unused_sync;

    cam_sync_edge u_sync_pclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cam_pclk),
        .level (pclk_lvl),
        .rise  (pclk_rise),
        .fall  (pclk_fall)
    );

    cam_sync_edge u_sync_vsync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cam_vsync),
        .level (vs_lvl),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    cam_sync_edge u_sync_href (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cam_href),
        .level (href_lvl),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    assign unused_sync = &{1'b0, pclk_lvl, pclk_fall, vs_lvl, href_rise};

    // Data takes the same two-flop delay as pclk so it lines up with pclk_rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            data_s1 <= cam_data;
            data_s2 <= data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (capture_req) state_d = ST_ARM;
            ST_ARM:  if (vs_fall) state_d = ST_CAPT;
            ST_CAPT: if ((wcnt_q == TOTAL) || vs_rise) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign start_frame = (state_q == ST_ARM) && vs_fall;
    assign in_window   = in_span(x_q, H_OFS, IMG_W) && in_span(y_q, V_OFS, IMG_H);

    // Pixel assembly, crop and VRAM write; the terminal count blocks any write past the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
            red_q   <= '0;
            wcnt_q  <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            short_q <= 1'b0;
        end else begin
            wea_q <= 1'b0;

            if ((state_q == ST_IDLE) && capture_req) begin
                short_q <= 1'b0;
            end
            if ((state_q == ST_DONE) && (wcnt_q < TOTAL)) begin
                short_q <= 1'b1;
            end

            if (start_frame) begin
                x_q     <= '0;
                y_q     <= '0;
                phase_q <= 1'b0;
                wcnt_q  <= '0;
            end else if (state_q == ST_CAPT) begin
                if (pclk_rise && href_lvl) begin
                    if (!phase_q) begin
                        red_q   <= data_s2[3:0];
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        x_q     <= (x_q == CNT_MAX) ? x_q : x_q + 1'b1;
                        if (in_window && (wcnt_q != TOTAL)) begin
                            wea_q   <= 1'b1;
                            addra_q <= wcnt_q[VRAM_AW-1:0];
                            dina_q  <= {red_q, data_s2};
                            wcnt_q  <= wcnt_q + 1'b1;
                        end
                    end
                end else if (href_fall && (x_q != '0)) begin
                    y_q     <= (y_q == CNT_MAX) ? y_q : y_q + 1'b1;
                    x_q     <= '0;
                    phase_q <= 1'b0;
                end
            end
        end
    end

    assign vram.wea   = wea_q;
    assign vram.addra = addra_q;
    assign vram.dina  = dina_q;

    assign busy        = (state_q == ST_ARM) || (state_q == ST_CAPT);
    assign frame_done  = (state_q == ST_DONE);
    assign short_frame = short_q;

endmodule

// File: tb/tb_cam_vram_writer.sv
// Directed bench for cam_vram_writer: 4x2 window at offset (1,1) over a 3-line, 6-pixel frame.
module tb_cam_vram_writer;

    logic       clk;
    logic       rst_n;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic       capture_req;
    logic       busy;
    logic       frame_done;
    logic       short_frame;

    cam_vram_writer_if vram_bus ();

    cam_vram_writer #(
        .IMG_W (4),
        .IMG_H (2),
        .H_OFS (1),
        .V_OFS (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cam_pclk    (cam_pclk),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .capture_req (capture_req),
        .vram        (vram_bus.master),
        .busy        (busy),
        .frame_done  (frame_done),
        .short_frame (short_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int line;
        int pix;
        int exp_addr;
        int exp_data;
    } vec_t;

    vec_t tbl[8];

    int cmp_n;
    int err_n;
    int cyc;
    int wr_n;
    int fd_n;
    int fd_cyc;
    int wr_addr[64];
    int wr_data[64];
    int wr_cyc[64];

    initial begin
        cmp_n = 0;
        err_n = 0;
        cyc   = 0;
        wr_n  = 0;
        fd_n  = 0;
        fd_cyc = 0;
    end

    always @(posedge clk) cyc++;

    // Write/frame_done log, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (vram_bus.wea) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = int'(vram_bus.addra);
                wr_data[wr_n] = int'(vram_bus.dina);
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        cmp_n++;
        if (actual !== expected) begin
            err_n++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One camera byte: data set while pclk is low, then a full pclk period (4 clk).
    task automatic applyStimulus(input logic [7:0] b);
        cam_pclk = 1'b0;
        cam_data = b;
        #20;
        cam_pclk = 1'b1;
        #20;
    endtask

    task automatic send_frame(input int n_lines, input int n_pix, input int cut, input bit pack);
        int win;
        logic [11:0] w;
        win = 0;
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        repeat (2) applyStimulus(8'h00);
        cam_vsync = 1'b0;
        repeat (2) applyStimulus(8'h00);
        for (int line = 0; line < n_lines; line++) begin
            if (cut >= 0 && win >= cut) break;
            cam_href = 1'b1;
            for (int pix = 0; pix < n_pix; pix++) begin
                if (cut >= 0 && win >= cut) break;
                w = 12'(line * 16 + pix);
                if (pack && line == 1 && pix == 1) w = 12'hA5C;
                applyStimulus({4'h0, w[11:8]});
                applyStimulus(w[7:0]);
                if (line >= 1 && line <= 2 && pix >= 1 && pix <= 4) win++;
            end
            cam_href = 1'b0;
            repeat (3) applyStimulus(8'h00);
        end
        cam_vsync = 1'b1;
        repeat (3) applyStimulus(8'h00);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        capture_req = 1'b1;
        @(negedge clk);
        capture_req = 1'b0;
    endtask

    task automatic clear_log();
        @(posedge clk);
        #1;
        wr_n = 0;
        fd_n = 0;
    endtask

    task automatic wait_done(input int exp);
        for (int i = 0; i < 400 && fd_n < exp; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 'h011};
        tbl[1] = '{1, 2, 1, 'h012};
        tbl[2] = '{1, 3, 2, 'h013};
        tbl[3] = '{1, 4, 3, 'h014};
        tbl[4] = '{2, 1, 4, 'h021};
        tbl[5] = '{2, 2, 5, 'h022};
        tbl[6] = '{2, 3, 6, 'h023};
        tbl[7] = '{2, 4, 7, 'h024};

        rst_n       = 1'b0;
        capture_req = 1'b1;
        cam_pclk    = 1'b0;
        cam_vsync   = 1'b0;
        cam_href    = 1'b1;
        cam_data    = 8'h00;

        // Reset held under live camera activity and a capture_req.
        repeat (5) begin
            @(negedge clk);
            cam_pclk  = ~cam_pclk;
            cam_vsync = ~cam_vsync;
            cam_data  = 8'($urandom);
        end
        checkOutput("rst_wea", int'(vram_bus.wea), 0);
        checkOutput("rst_addra", int'(vram_bus.addra), 0);
        checkOutput("rst_dina", int'(vram_bus.dina), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_short_frame", int'(short_frame), 0);
        capture_req = 1'b0;
        cam_pclk    = 1'b0;
        cam_href    = 1'b0;
        cam_vsync   = 1'b1;
        cam_data    = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("busy_after_rst", int'(busy), 0);

        // Full frame: 8 writes in row-major order, frame_done one clk after the last.
        clear_log();
        pulse_req();
        checkOutput("busy_armed", int'(busy), 1);
        send_frame(3, 6, -1, 1'b0);
        wait_done(1);
        checkOutput("full_wr_count", wr_n, 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("full_addr[%0d]", i), wr_addr[i], tbl[i].exp_addr);
            checkOutput($sformatf("full_data[%0d] l%0d p%0d", i, tbl[i].line, tbl[i].pix),
                        wr_data[i], tbl[i].exp_data);
        end
        checkOutput("full_fd_count", fd_n, 1);
        checkOutput("full_fd_latency", fd_cyc - wr_cyc[7], 1);
        checkOutput("full_short", int'(short_frame), 0);
        checkOutput("full_busy_end", int'(busy), 0);

        // Byte packing, with a capture_req pulsed mid-frame that must be ignored.
        clear_log();
        pulse_req();
        fork
            send_frame(3, 6, -1, 1'b1);
            begin
                repeat (60) @(negedge clk);
                capture_req = 1'b1;
                @(negedge clk);
                capture_req = 1'b0;
            end
        join
        wait_done(1);
        checkOutput("pack_wr_count", wr_n, 8);
        checkOutput("pack_dina", wr_data[0], 'hA5C);
        checkOutput("pack_next_data", wr_data[1], 'h012);
        checkOutput("busyreq_fd_count", fd_n, 1);

        // No new request: the following frame must not be captured.
        clear_log();
        send_frame(3, 6, -1, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("noreq_wr_count", wr_n, 0);
        checkOutput("noreq_fd_count", fd_n, 0);
        checkOutput("noreq_busy", int'(busy), 0);

        // Short frame: vsync rises after 5 of 8 window pixels.
        clear_log();
        pulse_req();
        send_frame(3, 6, 5, 1'b0);
        wait_done(1);
        checkOutput("short_wr_count", wr_n, 5);
        checkOutput("short_last_addr", wr_addr[4], 4);
        checkOutput("short_last_data", wr_data[4], 'h021);
        checkOutput("short_fd_count", fd_n, 1);
        checkOutput("short_flag", int'(short_frame), 1);
        pulse_req();
        checkOutput("short_cleared", int'(short_frame), 0);
        checkOutput("short_rearm_busy", int'(busy), 1);

        // Reset after the third write abandons the frame silently.
        clear_log();
        fork
            send_frame(3, 6, -1, 1'b0);
            begin
                for (int i = 0; i < 3000 && wr_n < 3; i++) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        checkOutput("midrst_wr_count", wr_n, 3);
        checkOutput("midrst_fd_count", fd_n, 0);
        checkOutput("midrst_busy", int'(busy), 0);

        // Re-capture after reset restarts at address 0.
        clear_log();
        pulse_req();
        send_frame(3, 6, -1, 1'b0);
        wait_done(1);
        checkOutput("recap_wr_count", wr_n, 8);
        checkOutput("recap_addr0", wr_addr[0], 0);
        checkOutput("recap_data0", wr_data[0], 'h011);
        checkOutput("recap_addr7", wr_addr[7], 7);
        checkOutput("recap_fd_count", fd_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
